aes_mix_one_column: RTL and testbench
=====================================

# aes_mix_one_column

Registered AES MixColumns transform for a single 4-byte state column, with an optional inverse (InvMixColumns) mode. It sits in the AES-128 round datapath after ShiftRows; four instances, or one time-multiplexed instance, cover the full 128-bit state. Input is captured on the clock edge and the result appears one cycle later with a matching valid flag.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  column/inverse are valid this cycle; capture them.
- inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with the column.
- column  input  32  input column. [31:24] = row 0 (a0), [23:16] = a1, [15:8] = a2, [7:0] = row 3 (a3).
- out_valid  output  1  mixed_column holds a new result this cycle.
- mixed_column  output  32  transformed column, same byte ordering (r0 in [31:24]).

## Operation
- All arithmetic is in GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B). Addition is XOR.
- xtime(b) = (b << 1) truncated to 8 bits, XOR 0x1B when b[7] = 1.
- Constant multiples are built from xtime chains and XOR:
  - 2b = xtime(b); 3b = xtime(b)^b
  - 9b = x3(b)^b; 0Bb = x3(b)^x(b)^b; 0Db = x3(b)^x2(b)^b; 0Eb = x3(b)^x2(b)^x(b)
- Forward mode (inverse = 0):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Inverse mode (inverse = 1):
  - r0 = 0Ea0^0Ba1^0Da2^09a3
  - r1 = 09a0^0Ea1^0Ba2^0Da3
  - r2 = 0Da0^09a1^0Ea2^0Ba3
  - r3 = 0Ba0^0Da1^09a2^0Ea3
- Each byte is computed with the same per-byte circuit applied to a rotation of the inputs; no lookup tables.
- There is no state machine and no backpressure. Every in_valid cycle produces exactly one result.

## Timing
- Latency: 1 cycle. A column presented with in_valid = 1 at edge N appears on mixed_column with out_valid = 1 after edge N.
- out_valid is in_valid registered.
- mixed_column updates only on in_valid cycles. Otherwise it holds its last value.
- Back-to-back in_valid gives one result per cycle at full throughput.
- Reset values: out_valid = 0, mixed_column = 32'h0.
- Reset assertion clears both outputs immediately, independent of clk, including mid-stream. An in-flight result is discarded.
- Deassertion is synchronized by the instantiating block. The first capture can happen on the first rising edge after rst_n goes high.
- inverse may change every cycle. Each result uses the inverse value sampled with its own column.
- The datapath contains no combinational path from inputs to outputs.

## Test plan
- Forward known vectors, back-to-back, one per cycle, inverse = 0:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - 01010101 -> 01010101
  - c6c6c6c6 -> c6c6c6c6
  - d4d4d4d5 -> d5d5d7d6
  - 2d26314c -> 4d7ebdf8
  - Each result arrives exactly 1 cycle after its input, with out_valid = 1.
- Inverse known vectors, inverse = 1:
  - 8e4da1bc -> db135345
  - 9fdc589d -> f20a225c
  - d5d5d7d6 -> d4d4d4d5
- Alternate the inverse bit on consecutive columns (f20a225c fwd, 9fdc589d inv) -> outputs 9fdc589d then f20a225c on consecutive cycles.
- Drive in_valid = 0 for 3 cycles after a result -> out_valid = 0 and mixed_column holds the previous value unchanged.
- Assert rst_n = 0 asynchronously between edges while out_valid = 1 -> out_valid = 0 and mixed_column = 0 immediately. First post-reset input 01010101 -> 01010101 one cycle later.
- Random regression: 10k random columns through forward then inverse (two passes) -> original column recovered. Forward results also match a software reference model.

Source files
------------

// File: rtl/aes_mix_one_column.sv
// Registered AES MixColumns / InvMixColumns for one 4-byte state column.
// One-cycle latency; out_valid is in_valid delayed by one clock.
module aes_mix_one_column (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        inverse,
  input  logic [31:0] column,
  output logic        out_valid,
  output logic [31:0] mixed_column
);

  logic [7:0]  a0_s, a1_s, a2_s, a3_s;
  logic [31:0] mixed_s;
  logic [31:0] mixed_r;
  logic        valid_r;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] red;
    red = b[7] ? 8'h1b : 8'h00;
    return {b[6:0], 1'b0} ^ red;
  endfunction

  // Per-byte mixer; b0 is the byte on the output's own row, b1..b3 follow it cyclically.
  // The inverse matrix equals the forward one plus 4*(b0^b2) plus 8*(b0^b1^b2^b3),
  // so the inverse reuses the forward sum instead of building four full multiplies.
  function automatic logic [7:0] mix_byte(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3,
    input logic       inv
  );
    logic [7:0] fwd;
    logic [7:0] x4;
    logic [7:0] x8;
    fwd = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    x4  = xtime(xtime(b0 ^ b2));
    x8  = xtime(xtime(xtime(b0 ^ b1 ^ b2 ^ b3)));
    return inv ? (fwd ^ x4 ^ x8) : fwd;
  endfunction

  assign a0_s = column[31:24];
  assign a1_s = column[23:16];
  assign a2_s = column[15:8];
  assign a3_s = column[7:0];

  // Same byte circuit on each rotation of the input column
  always_comb begin
    mixed_s = {mix_byte(a0_s, a1_s, a2_s, a3_s, inverse),
               mix_byte(a1_s, a2_s, a3_s, a0_s, inverse),
               mix_byte(a2_s, a3_s, a0_s, a1_s, inverse),
               mix_byte(a3_s, a0_s, a1_s, a2_s, inverse)};
  end

  // Output registers; result held between valid inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      mixed_r <= 32'h0000_0000;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        mixed_r <= mixed_s;
      end
    end
  end

  assign out_valid    = valid_r;
  assign mixed_column = mixed_r;

endmodule

// File: tb/tb_aes_mix_one_column.sv
// Scoreboard bench for aes_mix_one_column: known vectors, idle hold,
// asynchronous reset, and a random forward/inverse round trip against a GF model.
module tb_aes_mix_one_column;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        inverse = 1'b0;
  logic [31:0] column = 32'h0;
  logic        out_valid;
  logic [31:0] mixed_column;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_out = 32'h0;

  aes_mix_one_column dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .inverse      (inverse),
    .column       (column),
    .out_valid    (out_valid),
    .mixed_column (mixed_column)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Circulant matrix-vector product over GF(2^8)
  function automatic logic [31:0] model(input logic [31:0] c, input logic inv);
    logic [7:0] coef_f[4];
    logic [7:0] coef_i[4];
    logic [7:0] a[4];
    logic [7:0] r[4];
    coef_f = '{8'h02, 8'h03, 8'h01, 8'h01};
    coef_i = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++)
        r[i] = r[i] ^ gmul(inv ? coef_i[(j-i+4)%4] : coef_f[(j-i+4)%4], a[j]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  task automatic send(input logic [31:0] c, input logic inv, input logic [31:0] exp_v);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    column   = c;
    inverse  = inv;
    e.val = exp_v;
    e.cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every presented result
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %h at cycle %0d, required no output", mixed_column, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        last_out <= mon_e.val;
        if (mixed_column !== mon_e.val || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d",
                   mixed_column, cyc, mon_e.val, mon_e.cyc);
        end
      end
    end
  end

  logic [31:0] fwd_in[6];
  logic [31:0] fwd_out[6];
  logic [31:0] rnd_in[$];
  logic [31:0] tmp;

  initial begin
    fwd_in  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    fwd_out = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

    repeat (3) @(negedge clk);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    check("reset_data", mixed_column, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) send(fwd_in[i], 1'b0, fwd_out[i]);
    send(32'h8e4da1bc, 1'b1, 32'hdb135345);
    send(32'h9fdc589d, 1'b1, 32'hf20a225c);
    send(32'hd5d5d7d6, 1'b1, 32'hd4d4d4d5);
    send(32'hf20a225c, 1'b0, 32'h9fdc589d);
    send(32'h9fdc589d, 1'b1, 32'hf20a225c);

    // Idle: output must hold the last result
    @(negedge clk);
    in_valid = 1'b0;
    column   = 32'hffffffff;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("idle_valid", {31'h0, out_valid}, 32'h0);
      check("idle_hold", mixed_column, 32'hf20a225c);
    end

    // Asynchronous reset between edges while a result is showing
    send(32'hdb135345, 1'b0, 32'h8e4da1bc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", {31'h0, out_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'h0, out_valid}, 32'h0);
    check("async_reset_data", mixed_column, 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      in_valid = 1'b1;
      inverse  = 1'b0;
      column   = 32'h01010101;
      e.val = 32'h01010101;
      e.cyc = cyc + 1;
      sb_q.push_back(e);
    end

    // Random forward pass, checked against the model
    for (int i = 0; i < 10000; i++) begin
      tmp = $urandom;
      rnd_in.push_back(tmp);
      send(tmp, 1'b0, model(tmp, 1'b0));
    end
    // Inverse pass on the forward results must recover the originals
    for (int i = 0; i < 10000; i++) begin
      send(model(rnd_in[i], 1'b0), 1'b1, rnd_in[i]);
    end
    // Mixed modes with gaps
    for (int i = 0; i < 200; i++) begin
      logic inv_b;
      tmp   = $urandom;
      inv_b = 1'($urandom_range(0, 1));
      send(tmp, inv_b, model(tmp, inv_b));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding results, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
